// File: rtl/regfile_pkg.sv
// Shared widths and the writeback-queue entry type for the 16x16 register file.
package regfile_pkg;
    localparam int REG_W    = 16;
    localparam int REG_ID_W = 4;
    localparam int NUM_REGS = 16;
    localparam logic [REG_ID_W-1:0] ZERO_REG = 4'd0;

    typedef struct packed {
        logic [REG_ID_W-1:0] regId;
        logic [REG_W-1:0]    data;
    } wbq_entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback request handshake between the datapath (master) and the queue (slave).
interface regfile_wb_queue_if;
    import regfile_pkg::*;

    logic                wb_valid;
    logic                wb_ready;
    logic [REG_ID_W-1:0] wb_reg;
    logic [REG_W-1:0]    wb_data;

    modport master (output wb_valid, wb_reg, wb_data, input wb_ready);
    modport slave  (input wb_valid, wb_reg, wb_data, output wb_ready);
endinterface

// File: rtl/wbq_match.sv
// Looks up one register id among the pending queue entries; reports a hit and
// the data of the youngest matching entry.
module wbq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wbq_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]       validMask,
    input  logic [PTR_W-1:0]       headPtr,
    input  logic [REG_ID_W-1:0]    lookupId,
    output logic                   hit,
    output logic [REG_W-1:0]       hitData
);
    logic [DEPTH-1:0] ageMatch;
    logic [REG_W-1:0] ageData [DEPTH];

    // Rotate slots into age order: age 0 is the head (oldest).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] slot;
            assign slot         = headPtr + PTR_W'(gi);
            assign ageMatch[gi] = validMask[slot] && (entries[slot].regId == lookupId);
            assign ageData[gi]  = entries[slot].data;
        end
    endgenerate

    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        // Later (younger) matches overwrite earlier ones.
        for (int k = 0; k < DEPTH; k++) begin
            if (ageMatch[k]) begin
                hit     = 1'b1;
                hitData = ageData[k];
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO in front of the register file write port, with read correction
// for pending writes. Define WBQ_BYPASS_EN to forward queued data instead of flagging a hazard.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_queue_if.slave   wb,
    input  logic                drain_en,
    output logic [REG_ID_W-1:0] rf_dst_reg,
    output logic                rf_write,
    output logic [REG_W-1:0]    rf_dst_data,
    input  logic [REG_ID_W-1:0] rd_reg1,
    input  logic [REG_ID_W-1:0] rd_reg2,
    input  logic [REG_W-1:0]    rf_src_data1,
    input  logic [REG_W-1:0]    rf_src_data2,
    output logic [REG_W-1:0]    rd_data1,
    output logic [REG_W-1:0]    rd_data2,
    output logic                rd_hazard,
    output logic [OCC_W-1:0]    occupancy
);
    wbq_entry_t [DEPTH-1:0] entryMem;
    wbq_entry_t             headEntry;
    logic [PTR_W-1:0]       headReg, headNext, tailReg, tailNext;
    logic [OCC_W-1:0]       occReg, occNext;
    logic [DEPTH-1:0]       validMask;
    logic                   pushEn, popEn;
    logic                   hit1, hit2;
    logic [REG_W-1:0]       hitData1, hitData2;

    assign wb.wb_ready = !rst && (occReg < OCC_W'(DEPTH));
    // R0 requests are handshaken but dropped here.
    assign pushEn      = wb.wb_valid && wb.wb_ready && (wb.wb_reg != ZERO_REG);
    assign popEn       = drain_en && (occReg != '0);
    assign headEntry   = (occReg != '0) ? entryMem[headReg] : '0;
    assign rf_write    = popEn;
    assign rf_dst_reg  = headEntry.regId;
    assign rf_dst_data = headEntry.data;
    assign occupancy   = occReg;

    always_comb begin
        headNext = headReg;
        tailNext = tailReg;
        occNext  = occReg;
        if (pushEn) tailNext = tailReg + PTR_W'(1);
        if (popEn)  headNext = headReg + PTR_W'(1);
        case ({pushEn, popEn})
            2'b10:   occNext = occReg + OCC_W'(1);
            2'b01:   occNext = occReg - OCC_W'(1);
            default: occNext = occReg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headReg <= '0;
            tailReg <= '0;
            occReg  <= '0;
        end else begin
            headReg <= headNext;
            tailReg <= tailNext;
            occReg  <= occNext;
        end
    end

    // Entry payload needs no reset: validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (pushEn) entryMem[tailReg] <= {wb.wb_reg, wb.wb_data};
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PTR_W-1:0] ageOff;
            assign ageOff        = PTR_W'(gi) - headReg;
            assign validMask[gi] = {1'b0, ageOff} < occReg;
        end
    endgenerate

    wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .entries(entryMem), .validMask(validMask), .headPtr(headReg),
        .lookupId(rd_reg1), .hit(hit1), .hitData(hitData1)
    );
    wbq_match #(.DEPTH(DEPTH)) u_match2 (
        .entries(entryMem), .validMask(validMask), .headPtr(headReg),
        .lookupId(rd_reg2), .hit(hit2), .hitData(hitData2)
    );

`ifdef WBQ_BYPASS_EN
    assign rd_data1  = (rd_reg1 == ZERO_REG) ? '0 : (hit1 ? hitData1 : rf_src_data1);
    assign rd_data2  = (rd_reg2 == ZERO_REG) ? '0 : (hit2 ? hitData2 : rf_src_data2);
    assign rd_hazard = 1'b0;
`else
    logic unusedHitData;
    assign unusedHitData = ^{hitData1, hitData2};
    assign rd_data1  = (rd_reg1 == ZERO_REG) ? '0 : rf_src_data1;
    assign rd_data2  = (rd_reg2 == ZERO_REG) ? '0 : rf_src_data2;
    assign rd_hazard = ((rd_reg1 != ZERO_REG) && hit1) || ((rd_reg2 != ZERO_REG) && hit2);
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table, wrap/reset sequences and a
// randomized phase against a queue-based reference model.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;
`ifdef WBQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                drainEn;
    logic [REG_ID_W-1:0] rfDstReg, rdReg1, rdReg2;
    logic                rfWrite, rdHazard;
    logic [REG_W-1:0]    rfDstData, rfSrcData1, rfSrcData2, rdData1, rdData2;
    logic [OCC_W-1:0]    occupancy;

    regfile_wb_queue_if wbIf ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb(wbIf), .drain_en(drainEn),
        .rf_dst_reg(rfDstReg), .rf_write(rfWrite), .rf_dst_data(rfDstData),
        .rd_reg1(rdReg1), .rd_reg2(rdReg2),
        .rf_src_data1(rfSrcData1), .rf_src_data2(rfSrcData2),
        .rd_data1(rdData1), .rd_data2(rdData2),
        .rd_hazard(rdHazard), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference: pending writes in order, plus a stand-in register file.
    wbq_entry_t       modelQ[$];
    logic [REG_W-1:0] regs [NUM_REGS];
    int tests = 0;
    int fails = 0;

    // Junk on R0 reads proves the queue forces zero itself.
    always_comb rfSrcData1 = (rdReg1 == 4'd0) ? 16'hDEAD : regs[rdReg1];
    always_comb rfSrcData2 = (rdReg2 == 4'd0) ? 16'hDEAD : regs[rdReg2];

    typedef struct {
        bit               wv;
        logic [3:0]       wr;
        logic [15:0]      wd;
        bit               de;
        logic [3:0]       r1;
        logic [2:0]       expOcc;
        bit               expReady;
        bit               expWrite;
        logic [3:0]       expDst;
        logic [15:0]      expDstData;
        logic [15:0]      expRdByp;
        logic [15:0]      expRdNob;
        bit               expHazNob;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [REG_W-1:0] modelRead(input logic [3:0] id);
        if (id == 4'd0) return '0;
        if (BYPASS)
            for (int i = modelQ.size() - 1; i >= 0; i--)
                if (modelQ[i].regId == id) return modelQ[i].data;
        return regs[id];
    endfunction

    function automatic bit pending(input logic [3:0] id);
        if (id == 4'd0) return 1'b0;
        foreach (modelQ[i]) if (modelQ[i].regId == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkModel(input string tag);
        bit expWrite;
        bit expHaz;
        expWrite = drainEn && (modelQ.size() > 0);
        expHaz   = !BYPASS && (pending(rdReg1) || pending(rdReg2));
        check({tag, "_occ"},   32'(occupancy), 32'(modelQ.size()));
        check({tag, "_ready"}, 32'(wbIf.wb_ready), 32'(!rst && modelQ.size() < DEPTH));
        check({tag, "_write"}, 32'(rfWrite), 32'(expWrite));
        check({tag, "_dst"},   32'(rfDstReg),  32'(modelQ.size() > 0 ? modelQ[0].regId : 4'd0));
        check({tag, "_ddat"},  32'(rfDstData), 32'(modelQ.size() > 0 ? modelQ[0].data : 16'd0));
        check({tag, "_rd1"},   32'(rdData1), 32'(modelRead(rdReg1)));
        check({tag, "_rd2"},   32'(rdData2), 32'(modelRead(rdReg2)));
        check({tag, "_haz"},   32'(rdHazard), 32'(expHaz));
    endtask

    task automatic stepModel();
        bit ready;
        bit pop;
        ready = !rst && (modelQ.size() < DEPTH);
        pop   = drainEn && (modelQ.size() > 0);
        if (rst) begin
            modelQ.delete();
        end else begin
            if (pop) begin
                regs[modelQ[0].regId] = modelQ[0].data;
                void'(modelQ.pop_front());
            end
            if (wbIf.wb_valid && ready && wbIf.wb_reg != 4'd0)
                modelQ.push_back('{regId: wbIf.wb_reg, data: wbIf.wb_data});
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] r, input logic [15:0] d,
                         input bit de, input logic [3:0] a1, input logic [3:0] a2);
        wbIf.wb_valid = v;
        wbIf.wb_reg   = r;
        wbIf.wb_data  = d;
        drainEn       = de;
        rdReg1        = a1;
        rdReg2        = a2;
    endtask

    task automatic cycle(input bit v, input logic [3:0] r, input logic [15:0] d,
                         input bit de, input logic [3:0] a1, input logic [3:0] a2,
                         input string tag);
        @(negedge clk);
        drive(v, r, d, de, a1, a2);
        #2;
        checkModel(tag);
        @(posedge clk);
        stepModel();
    endtask

    initial begin
        //            wv    wr     wd        de    r1     occ   rdy   wr    dst    ddat      rdByp     rdNob     haz
        vecs[0]  = '{1'b1, 4'd3, 16'h1234, 1'b1, 4'd3, 3'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 3'd1, 1'b1, 1'b1, 4'd3, 16'h1234, 16'h1234, 16'h0000, 1'b1};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 3'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h1234, 16'h1234, 1'b0};
        vecs[3]  = '{1'b1, 4'd1, 16'h1111, 1'b0, 4'd1, 3'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 4'd2, 16'h2222, 1'b0, 4'd1, 3'd1, 1'b1, 1'b0, 4'd1, 16'h1111, 16'h1111, 16'h0000, 1'b1};
        vecs[5]  = '{1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 3'd2, 1'b1, 1'b0, 4'd1, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 3'd3, 1'b1, 1'b0, 4'd1, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 3'd4, 1'b0, 1'b0, 4'd1, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 4'd7, 16'h7777, 1'b1, 4'd0, 3'd4, 1'b0, 1'b1, 4'd1, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 4'd7, 16'h7777, 1'b1, 4'd0, 3'd3, 1'b1, 1'b1, 4'd2, 16'h2222, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 3'd3, 1'b1, 1'b1, 4'd4, 16'h4444, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 3'd2, 1'b1, 1'b1, 4'd6, 16'h6666, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 3'd1, 1'b1, 1'b1, 4'd7, 16'h7777, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b1, 4'd5, 16'hAAAA, 1'b0, 4'd5, 3'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[14] = '{1'b1, 4'd5, 16'hBBBB, 1'b0, 4'd5, 3'd1, 1'b1, 1'b0, 4'd5, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1};
        vecs[15] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 3'd2, 1'b1, 1'b0, 4'd5, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b1};
        vecs[16] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 3'd2, 1'b1, 1'b1, 4'd5, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b1};
        vecs[17] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 3'd1, 1'b1, 1'b1, 4'd5, 16'hBBBB, 16'hBBBB, 16'hAAAA, 1'b1};
        vecs[18] = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd5, 3'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'hBBBB, 16'hBBBB, 1'b0};
        vecs[19] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 3'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 16'hBBBB, 16'hBBBB, 1'b0};

        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        rst = 1'b1;
        drive(1'b1, 4'd3, 16'h5555, 1'b1, 4'd3, 4'd0);

        // Reset state, with requests and drain pressure applied.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_ready", 32'(wbIf.wb_ready), 32'd0);
        check("rst_write", 32'(rfWrite), 32'd0);
        check("rst_haz",   32'(rdHazard), 32'd0);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].wv, vecs[i].wr, vecs[i].wd, vecs[i].de, vecs[i].r1, 4'd0);
            #2;
            check($sformatf("vec%0d_occ", i),   32'(occupancy), 32'(vecs[i].expOcc));
            check($sformatf("vec%0d_ready", i), 32'(wbIf.wb_ready), 32'(vecs[i].expReady));
            check($sformatf("vec%0d_write", i), 32'(rfWrite), 32'(vecs[i].expWrite));
            check($sformatf("vec%0d_dst", i),   32'(rfDstReg), 32'(vecs[i].expDst));
            check($sformatf("vec%0d_ddat", i),  32'(rfDstData), 32'(vecs[i].expDstData));
            check($sformatf("vec%0d_rd1", i),   32'(rdData1),
                  32'(BYPASS ? vecs[i].expRdByp : vecs[i].expRdNob));
            check($sformatf("vec%0d_rd2", i),   32'(rdData2), 32'd0);
            check($sformatf("vec%0d_haz", i),   32'(rdHazard), 32'(BYPASS ? 1'b0 : vecs[i].expHazNob));
            checkModel($sformatf("vec%0d_m", i));
            @(posedge clk);
            stepModel();
        end

        // Steady state at occupancy 2: push and pop every cycle, pointers wrap.
        cycle(1'b1, 4'd8, 16'h0800, 1'b0, 4'd8, 4'd9, "wrap_fill0");
        cycle(1'b1, 4'd9, 16'h0900, 1'b0, 4'd8, 4'd9, "wrap_fill1");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 4'(10 + (i % 5)), 16'(16'hC000 + i), 1'b1, 4'(10 + (i % 5)), 4'd9);
            #2;
            check($sformatf("wrap%0d_occ", i), 32'(occupancy), 32'd2);
            checkModel($sformatf("wrap%0d", i));
            @(posedge clk);
            stepModel();
        end
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd12, 4'd13, $sformatf("wrap_drain%0d", i));

        // Asynchronous reset with three entries pending.
        cycle(1'b1, 4'd2, 16'h0202, 1'b0, 4'd0, 4'd0, "ar_push0");
        cycle(1'b1, 4'd3, 16'h0303, 1'b0, 4'd0, 4'd0, "ar_push1");
        cycle(1'b1, 4'd4, 16'h0404, 1'b0, 4'd0, 4'd0, "ar_push2");
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd0);
        #2;
        checkModel("ar_pre");
        rst = 1'b1;
        #1;
        check("ar_occ",   32'(occupancy), 32'd0);
        check("ar_write", 32'(rfWrite), 32'd0);
        check("ar_ready", 32'(wbIf.wb_ready), 32'd0);
        check("ar_haz",   32'(rdHazard), 32'd0);
        modelQ.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd4, $sformatf("ar_post%0d", i));

        // Randomized traffic; small id range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 60), 4'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 99) < 55), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
